// File: rtl/pipe_trace_buffer_if.sv
// Capture and read-out handshake bundle for the pipeline trace buffer.
// The producer/consumer side uses master; the buffer itself uses slave.
interface pipe_trace_buffer_if #(
  parameter int PC_W = 32
);
  logic              cap_valid;
  logic [31:0]       inst;
  logic [PC_W-1:0]   pc;
  logic              rd_ready;
  logic              rd_valid;
  logic [34+PC_W:0]  rd_data;

  modport master (output cap_valid, inst, pc, rd_ready, input rd_valid, rd_data);
  modport slave  (input cap_valid, inst, pc, rd_ready, output rd_valid, rd_data);
endinterface

// File: rtl/pipe_trace_buffer.sv
// Pipeline instruction trace buffer: classifies captured instructions, stores
// {class, inst, pc} records in a circular buffer and keeps per-class counters.
module pipe_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 32,
  parameter int POST  = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic                   trigger,
  pipe_trace_buffer_if.slave     bus,
  input  logic [2:0]             cls_sel,
  output logic [CNT_W-1:0]       cls_count,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             state,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int RW = 35 + PC_W;

  localparam logic [AW-1:0]    PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0]    PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]      OCC_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]      OCC_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]      OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]      OCC_LAST = OCC_FULL - OCC_ONE;
  localparam logic [PW-1:0]    PST_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]    PST_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    PST_LOAD = PW'(POST);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_t;

  function automatic logic [2:0] classify(input logic [5:0] op);
    case (op)
      6'b000010:                                classify = 3'd1;
      6'b010000, 6'b010001, 6'b010010:          classify = 3'd2;
      6'b011000, 6'b011001, 6'b011010:          classify = 3'd3;
      6'b001000, 6'b001101, 6'b101101, 6'b100101: classify = 3'd4;
      6'b111010, 6'b100000, 6'b100010:          classify = 3'd5;
      6'b110100, 6'b110101:                     classify = 3'd6;
      default:                                  classify = 3'd0;
    endcase
  endfunction

  state_t           state_r;
  logic [1:0]       mode_r;
  logic [AW-1:0]    head_r;
  logic [AW-1:0]    tail_r;
  logic [AW:0]      count_r;
  logic             overflow_r;
  logic [PW-1:0]    post_r;
  logic [RW-1:0]    mem_r [DEPTH];
  logic [CNT_W-1:0] cnt_r [8];

  logic       capture_s;
  logic       pop_s;
  logic       full_s;
  logic [2:0] cls_s;

  // start takes priority, so it masks both capture and pop
  assign capture_s = bus.cap_valid && !start && (state_r == ST_RUN || state_r == ST_POST);
  assign pop_s     = bus.rd_ready && !start && (count_r != OCC_ZERO);
  assign full_s    = (count_r == OCC_FULL);
  assign cls_s     = classify(bus.inst[31:26]);

  assign bus.rd_valid = (count_r != OCC_ZERO);
  assign bus.rd_data  = mem_r[head_r];
  assign cls_count    = cnt_r[cls_sel];
  assign count        = count_r;
  assign state        = state_r;
  assign overflow     = overflow_r;

  // Capture FSM, ring pointers, occupancy and overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      mode_r     <= 2'd0;
      head_r     <= PTR_ZERO;
      tail_r     <= PTR_ZERO;
      count_r    <= OCC_ZERO;
      overflow_r <= 1'b0;
      post_r     <= PST_ZERO;
    end else if (start) begin
      state_r    <= ST_RUN;
      mode_r     <= mode;
      head_r     <= PTR_ZERO;
      tail_r     <= PTR_ZERO;
      count_r    <= OCC_ZERO;
      overflow_r <= 1'b0;
      post_r     <= PST_ZERO;
    end else begin
      if (capture_s) tail_r <= tail_r + PTR_ONE;
      // a capture into a full ring drops the oldest entry
      if (pop_s || (capture_s && full_s)) head_r <= head_r + PTR_ONE;
      if (capture_s && !pop_s && !full_s) count_r <= count_r + OCC_ONE;
      else if (pop_s && !capture_s) count_r <= count_r - OCC_ONE;
      if (capture_s && !pop_s && full_s) overflow_r <= 1'b1;
      case (state_r)
        ST_RUN: begin
          if (mode_r == 2'd1 && capture_s && !pop_s && count_r == OCC_LAST) begin
            state_r <= ST_FROZEN;
          end else if (mode_r == 2'd2 && trigger) begin
            state_r <= ST_POST;
            post_r  <= PST_LOAD;
          end
        end
        ST_POST: begin
          if (capture_s) begin
            post_r <= post_r - PST_ONE;
            if (post_r == PST_ONE) state_r <= ST_FROZEN;
          end
        end
        ST_IDLE, ST_FROZEN: state_r <= state_r;
        default:            state_r <= ST_IDLE;
      endcase
    end
  end

  // Trace storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (capture_s) mem_r[tail_r] <= {cls_s, bus.inst, bus.pc};
  end

  // Saturating per-class capture counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '{default: CNT_ZERO};
    end else if (start) begin
      cnt_r <= '{default: CNT_ZERO};
    end else if (capture_s && cnt_r[cls_s] != CNT_MAX) begin
      cnt_r[cls_s] <= cnt_r[cls_s] + CNT_ONE;
    end
  end

endmodule

// File: doc/pipe_trace_buffer.md
PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: trace entries, power of two, at least 4.
REQ-002 SHALL have parameter PC_W, default 32: width of the captured PC.
REQ-003 SHALL have parameter POST, default 8: records captured after a trigger in mode 2, range 1..DEPTH.
REQ-004 SHALL have parameter CNT_W, default 16: width of the per-class counters.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: clears the buffer and counters, then arms capture.
REQ-008 SHALL have port mode, input, 2 bits: capture mode, sampled on start.
REQ-009 SHALL have port trigger, input, 1 bit: trigger event, used in mode 2.
REQ-010 SHALL have port cap_valid, input, 1 bit: instruction-register load-enable qualifier.
REQ-011 SHALL have port inst, input, 32 bits: instruction word.
REQ-012 SHALL have port pc, input, PC_W bits: front PC paired with inst.
REQ-013 SHALL have port rd_ready, input, 1 bit: consumer pops the head entry.
REQ-014 SHALL have port rd_valid, output, 1 bit: head entry available.
REQ-015 SHALL have port rd_data, output, 35+PC_W bits: packed {class[2:0], inst[31:0], pc}.
REQ-016 SHALL have port count, output, clog2(DEPTH)+1 bits: current occupancy.
REQ-017 SHALL have port state, output, 2 bits: encoded as IDLE=0, RUN=1, POST=2, FROZEN=3.
REQ-018 SHALL have port overflow, output, 1 bit: sticky flag, set when an entry was overwritten.
REQ-019 SHALL have port cls_sel, input, 3 bits: selects a class counter.
REQ-020 SHALL have port cls_count, output, CNT_W bits: selected counter value, combinational.

Function
REQ-021 SHALL classify inst[31:26] as follows:
- 000010 -> 1 ARITH
- 010000/010001/010010 -> 2 LOAD
- 011000/011001/011010 -> 3 STORE
- 001000/001101/101101/100101 -> 4 IMM
- 111010/100000/100010 -> 5 BRANCH
- 110100/110101 -> 6 SHIFT
- any other opcode -> 0 NOP; class 7 is unused and its counter stays 0.
REQ-022 SHALL define capture as cap_valid=1 while state is RUN or POST and start=0; each capture writes one record at the tail.
REQ-023 SHALL make a record captured at edge N visible on rd_data/rd_valid after edge N (one-cycle latency).
REQ-024 SHALL keep rd_data combinational from the head entry (show-ahead) and drive rd_valid=(count!=0) in every state.
REQ-025 SHALL pop the head on rd_valid&rd_ready at the clock edge; with rd_valid=0, rd_ready SHALL be ignored.
REQ-026 SHALL, on a simultaneous capture and pop, leave count unchanged and raise no overflow.
REQ-027 SHALL, in mode 0 (wrap) at count=DEPTH with capture and no pop, overwrite the oldest entry, advance the head, hold count, and set overflow.
REQ-028 SHALL, in mode 1 (stop-on-full), enter FROZEN on the capture that makes count=DEPTH; that record SHALL be stored.
REQ-029 SHALL, in mode 2 (post-trigger), take RUN->POST on trigger=1 and load the remaining counter with POST; the trigger-cycle capture (if any) SHALL be stored and not decrement the counter.
REQ-030 SHALL, in POST, decrement the counter on each capture and enter FROZEN on the capture that reaches 0; wrap behaviour SHALL be as REQ-027.
REQ-031 SHALL treat mode 3 as mode 0, and SHALL ignore trigger in modes 0, 1 and 3.
REQ-032 SHALL perform no capture in IDLE or FROZEN; pops SHALL still be permitted there.
REQ-033 SHALL, on start=1 in any state, clear head, tail, count, overflow and all class counters, latch mode, and enter RUN; start SHALL win over any same-cycle capture, pop or trigger.
REQ-034 SHALL increment counter[class] by 1 on each capture, saturating at 2^CNT_W-1.
REQ-035 SHALL wrap head and tail pointers modulo DEPTH.

Reset
REQ-036 SHALL, on reset=0 asynchronously, force state=IDLE, count=0, overflow=0, rd_valid=0, pointers=0, all counters=0 and latched mode=0.
REQ-037 SHALL NOT require the buffer storage to be reset; rd_data is don't-care while rd_valid=0.
REQ-038 SHALL, when reset is asserted mid-capture or mid-POST, abandon the operation and leave the block in IDLE until start.

Verification
REQ-039 SHALL cover: reset, start with mode=0, 3 captures of ADD (inst[31:26]=000010), LDW (010010), BL (111010) -> count=3; pops return classes 1, 2, 5 in order; cls_count[1]=1.
REQ-040 SHALL cover: mode 0, DEPTH=16, 20 captures with no pops -> count=16, overflow=1, head record = 5th captured PC.
REQ-041 SHALL cover: mode 1, 16 captures -> state=3 after the 16th; a 17th cap_valid is not stored; one pop -> count=15 and state stays 3.
REQ-042 SHALL cover: mode 2, POST=8, trigger on capture #5 -> state=3 after capture #13, buffer holds records 1..13.
REQ-043 SHALL cover: start and cap_valid in the same cycle while FROZEN with count=9 -> next cycle count=0, state=1, overflow=0, counters=0.
REQ-044 SHALL cover: reset pulled low mid-POST -> state=0 and count=0 immediately, without waiting for a clock edge.
